// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pkg
//  Description : Shared types and compare function for the streaming
//                comparator / frame statistics tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    // Widest operand the shared compare function handles; narrower operands
    // are sign- or zero-extended up to this width before comparison.
    localparam int c_MAX_W = 64;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_res_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } trk_state_t;

    // Operands arrive already extended to c_MAX_W in the requested mode, so a
    // single full-width compare gives the right answer for any WIDTH.
    function automatic cmp_res_t cmp_fn(input logic [c_MAX_W-1:0] a,
                                        input logic [c_MAX_W-1:0] b,
                                        input logic               is_signed);
        cmp_res_t r;
        r.eq = (a == b);
        if (is_signed) begin
            r.gt = ($signed(a) > $signed(b));
            r.lt = ($signed(a) < $signed(b));
        end else begin
            r.gt = (a > b);
            r.lt = (a < b);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_core.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_core
//  Description : Combinational signed/unsigned magnitude compare of two
//                WIDTH-bit operands (WIDTH up to 64).
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output cmp_res_t         res
);

    logic [c_MAX_W-1:0] w_a_ext;
    logic [c_MAX_W-1:0] w_b_ext;

    // Extend both operands to the package width; the fill bit is the sign
    // bit in signed mode and zero otherwise.
    generate
        if (WIDTH < c_MAX_W) begin : g_ext
            assign w_a_ext = {{(c_MAX_W-WIDTH){is_signed & a[WIDTH-1]}}, a};
            assign w_b_ext = {{(c_MAX_W-WIDTH){is_signed & b[WIDTH-1]}}, b};
        end else begin : g_full
            assign w_a_ext = a;
            assign w_b_ext = b;
        end
    endgenerate

    // Single full-width compare.
    always_comb begin
        res = cmp_fn(w_a_ext, w_b_ext, is_signed);
    end

endmodule
`default_nettype wire

// File: rtl/cmp_stream_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_stream_tracker
//  Description : Streaming valid/ready comparator with registered result,
//                saturating per-frame outcome counters and running max/min
//                of operand a.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_stream_tracker
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [WIDTH-1:0] max_a,
    output logic [WIDTH-1:0] min_a,
    output logic             ext_valid,
    output logic             mode_q
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_out_valid;
    cmp_res_t         r_res;
    logic [CNT_W-1:0] r_cnt_gt, r_cnt_lt, r_cnt_eq;
    logic [WIDTH-1:0] r_max, r_min;
    logic             r_mode;
    trk_state_t       r_state, w_state_nxt;

    logic             w_accept;
    logic             w_mode;
    logic             w_first;
    logic             w_max_upd, w_min_upd;
    cmp_res_t         w_beat, w_max_res, w_min_res;

    assign in_ready  = !r_out_valid | out_ready;
    assign w_accept  = in_valid & in_ready;
    // A beat accepted together with clear belongs to the new frame and its mode.
    assign w_mode    = clear ? signed_mode : r_mode;
    assign w_first   = clear | (r_state == EMPTY);
    // Qualify with the one-hot shape of the compare result.
    assign w_max_upd = w_max_res.gt & ~w_max_res.lt & ~w_max_res.eq;
    assign w_min_upd = w_min_res.lt & ~w_min_res.gt & ~w_min_res.eq;

    cmp_core #(.WIDTH(WIDTH)) u_cmp_beat (.a(a), .b(b),     .is_signed(w_mode), .res(w_beat));
    cmp_core #(.WIDTH(WIDTH)) u_cmp_max  (.a(a), .b(r_max), .is_signed(w_mode), .res(w_max_res));
    cmp_core #(.WIDTH(WIDTH)) u_cmp_min  (.a(a), .b(r_min), .is_signed(w_mode), .res(w_min_res));

    // Result register: load on accept, drop when consumed without a new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_res       <= w_beat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Frame mode, reloaded on every clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= 1'b1;
        end else if (clear) begin
            r_mode <= signed_mode;
        end
    end

    // Saturating outcome counters; clear restarts them from the current beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_gt <= '0;
            r_cnt_lt <= '0;
            r_cnt_eq <= '0;
        end else if (clear) begin
            r_cnt_gt <= (w_accept & w_beat.gt) ? c_CNT_ONE : '0;
            r_cnt_lt <= (w_accept & w_beat.lt) ? c_CNT_ONE : '0;
            r_cnt_eq <= (w_accept & w_beat.eq) ? c_CNT_ONE : '0;
        end else if (w_accept) begin
            if (w_beat.gt && r_cnt_gt != c_CNT_MAX) r_cnt_gt <= r_cnt_gt + c_CNT_ONE;
            if (w_beat.lt && r_cnt_lt != c_CNT_MAX) r_cnt_lt <= r_cnt_lt + c_CNT_ONE;
            if (w_beat.eq && r_cnt_eq != c_CNT_MAX) r_cnt_eq <= r_cnt_eq + c_CNT_ONE;
        end
    end

    // Tracker state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tracker next state: clear empties the frame, any accept makes it valid.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = EMPTY;
        end
        if (w_accept) begin
            w_state_nxt = TRACK;
        end
    end

    // Tracker output decode.
    always_comb begin
        ext_valid = (r_state == TRACK);
    end

    // Extreme registers: seed on the first sample of a frame, then track.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
            r_min <= '0;
        end else if (w_accept) begin
            if (w_first) begin
                r_max <= a;
                r_min <= a;
            end else begin
                if (w_max_upd) r_max <= a;
                if (w_min_upd) r_min <= a;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign gt        = r_res.gt;
    assign lt        = r_res.lt;
    assign eq        = r_res.eq;
    assign cnt_gt    = r_cnt_gt;
    assign cnt_lt    = r_cnt_lt;
    assign cnt_eq    = r_cnt_eq;
    assign max_a     = r_max;
    assign min_a     = r_min;
    assign mode_q    = r_mode;

endmodule
`default_nettype wire
